// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter/sequencer sharing one UART transmitter
// Splits granted words into LSB-first bytes paced by thre, waits for tend, owns baud writes.
module uart_tx_arbiter #(
  parameter int         N         = 4,
  parameter int         IDW       = 2,
  parameter logic [8:0] DEF_DIV   = 9'd7,
  parameter int         GUARD_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [32*N-1:0]  req_data,
  input  logic [2*N-1:0]   req_len,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     done,
  input  logic [8:0]       cfg_div,
  input  logic             cfg_wr,
  output logic [31:0]      uart_d,
  output logic             uart_wrtx,
  output logic             uart_wrbaud,
  input  logic             uart_thre,
  input  logic             uart_tend,
  output logic             busy,
  output logic [IDW-1:0]   cur_id
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CFG, S_ISSUE, S_GUARD, S_DRAIN} state_t;

  state_t         state, state_nx;
  logic           armed;
  logic [IDW-1:0] last, cur_q, sel, cand;
  logic           found, grant;
  logic [31:0]    word_q;
  logic [1:0]     len_q, idx_q;
  logic [2:0]     gcnt;
  logic           cfg_pend;
  logic [8:0]     div_reg;
  logic           guard_end;

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign grant     = (state == S_IDLE) && !cfg_pend && found;
  assign guard_end = (gcnt == 3'(GUARD_CYC - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (armed) state_nx = S_IDLE;
      S_IDLE:  if (cfg_pend) state_nx = S_CFG;
               else if (found) state_nx = S_ISSUE;
      S_CFG:   state_nx = S_IDLE;
      S_ISSUE: if (uart_thre) state_nx = S_GUARD;
      S_GUARD: if (guard_end) state_nx = (idx_q == len_q) ? S_DRAIN : S_ISSUE;
      S_DRAIN: if (uart_tend) state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  // INIT waits one cycle after reset release so wrbaud stays low while in reset.
  always_comb begin
    uart_wrbaud = ((state == S_INIT) && armed) || (state == S_CFG);
    uart_wrtx   = (state == S_ISSUE) && uart_thre;
    uart_d      = '0;
    if (uart_wrbaud)
      uart_d = {23'b0, div_reg};
    else if (uart_wrtx)
      uart_d = {24'b0, word_q[8*idx_q +: 8]};
    gnt  = grant ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
    done = ((state == S_DRAIN) && uart_tend) ? ({{(N-1){1'b0}}, 1'b1} << cur_q) : '0;
    busy   = (state != S_IDLE);
    cur_id = cur_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      armed    <= 1'b0;
      last     <= IDW'(N - 1);
      cur_q    <= '0;
      word_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      gcnt     <= '0;
      cfg_pend <= 1'b0;
      div_reg  <= DEF_DIV;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (grant) begin
        word_q <= req_data[32*sel +: 32];
        len_q  <= req_len[2*sel +: 2];
        idx_q  <= '0;
        last   <= sel;
        cur_q  <= sel;
      end
      gcnt <= (state == S_GUARD) ? gcnt + 3'd1 : 3'd0;
      if ((state == S_GUARD) && guard_end && (idx_q != len_q))
        idx_q <= idx_q + 2'd1;
      // A strobe landing on the CFG cycle must survive the clear.
      if (cfg_wr) begin
        cfg_pend <= 1'b1;
        div_reg  <= cfg_div;
      end else if (state == S_CFG) begin
        cfg_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
// A small behavioural transmitter model supplies thre/tend; monitors log bytes, grants, dones and baud writes.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] req_data = '0;
  logic [2*N-1:0]  req_len = '0;
  logic [8:0]      cfg_div = '0;
  logic            cfg_wr = 1'b0;
  logic [N-1:0]    gnt, done;
  logic [31:0]     uart_d;
  logic            uart_wrtx, uart_wrbaud, uart_thre, uart_tend, busy;
  logic [1:0]      cur_id;

  uart_tx_arbiter #(.N(N), .IDW(2), .DEF_DIV(9'd7), .GUARD_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_len(req_len),
    .gnt(gnt), .done(done), .cfg_div(cfg_div), .cfg_wr(cfg_wr), .uart_d(uart_d),
    .uart_wrtx(uart_wrtx), .uart_wrbaud(uart_wrbaud), .uart_thre(uart_thre),
    .uart_tend(uart_tend), .busy(busy), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  // Transmitter model: one holding register feeding a shifter, frame = 4*(div+1) cycles.
  logic       hold_full, shifting;
  int         cnt;
  logic [8:0] div_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0; shifting <= 1'b0; cnt <= 0; div_m <= '0;
    end else begin
      if (uart_wrbaud) div_m <= uart_d[8:0];
      if (uart_wrtx) hold_full <= 1'b1;
      if (shifting) begin
        if (cnt <= 1) shifting <= 1'b0;
        else cnt <= cnt - 1;
      end else if (hold_full) begin
        shifting  <= 1'b1;
        cnt       <= 4 * (int'(div_m) + 1);
        hold_full <= 1'b0;
      end
    end
  end
  assign uart_thre = !hold_full;
  assign uart_tend = !hold_full && !shifting;

  int         total = 0, bad = 0, viol = 0;
  logic [7:0] byte_log[$];
  int         baud_log[$];
  int         ev[$];

  function automatic int oh(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Event codes: grant i -> i, done i -> 16+i, baud write -> 32.
  always @(negedge clk) begin
    if (uart_wrtx) byte_log.push_back(uart_d[7:0]);
    if (uart_wrbaud) begin baud_log.push_back(int'(uart_d)); ev.push_back(32); end
    if (gnt != '0) ev.push_back(oh(gnt));
    if (done != '0) ev.push_back(16 + oh(done));
    if ((uart_wrtx && uart_wrbaud) || (uart_wrtx && !uart_thre) ||
        (uart_wrtx && uart_d[31:8] != 24'h0) || !$onehot0(gnt) || !$onehot0(done))
      viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int id);
    id = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (gnt != '0) begin id = oh(gnt); return; end
    end
    tmo("wait_gnt");
  endtask

  task automatic wait_done(output int id, output int cyc);
    id = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done != '0) begin id = oh(done); cyc = i; return; end
    end
    cyc = 1000;
    tmo("wait_done");
  endtask

  task automatic wait_wrtx(input int n);
    int seen = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (uart_wrtx) seen++;
      if (seen == n) return;
    end
    tmo("wait_wrtx");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    tmo("wait_idle");
  endtask

  logic [7:0] exp2[4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] exp6[5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h12};

  initial begin
    int id, cyc, b0, e0, nb0, e1;

    // Reset values and the single INIT baud write
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_wrbaud", uart_wrbaud, 0);
    chk("rst_wrtx", uart_wrtx, 0);
    chk("rst_d", uart_d, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_cur_id", cur_id, 0);
    step(); rst_n = 1'b1;
    wait_idle(); #1;
    chk("init_baud_cnt", baud_log.size(), 1);
    chk("init_baud_val", baud_log[0], 32'h7);
    chk("init_no_wrtx", byte_log.size(), 0);

    // Four-byte word, LSB first
    b0 = byte_log.size(); e0 = ev.size();
    step(); req_data[31:0] = 32'h11223344; req_len[1:0] = 2'd3; req[0] = 1'b1;
    wait_gnt(id); chk("t2_gnt", id, 0);
    step(); req[0] = 1'b0;
    wait_done(id, cyc); chk("t2_done", id, 0);
    #1;
    chk("t2_nbytes", byte_log.size() - b0, 4);
    for (int k = 0; k < 4; k++) chk("t2_byte", byte_log[b0+k], exp2[k]);
    chk("t2_nevents", ev.size() - e0, 2);

    // All four requesting after a fresh reset: rotation 0,1,2,3,0
    step(); rst_n = 1'b0;
    req_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; req_len = '0; req = 4'hF;
    e0 = ev.size(); b0 = byte_log.size();
    step(); step(); rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(id); chk("t3_gnt_order", id, g % 4);
      if (g == 4) begin step(); req = '0; end
      wait_done(id, cyc); chk("t3_done", id, g % 4);
    end
    #1;
    chk("t3_first_baud", ev[e0], 32);
    for (int g = 0; g < 5; g++) begin
      chk("t3_ev_gnt", ev[e0+1+2*g], g % 4);
      chk("t3_ev_done", ev[e0+2+2*g], 16 + g % 4);
      chk("t3_byte", byte_log[b0+g], 8'hA0 + 8'(g % 4));
    end

    // Config written mid-transfer is deferred until after done, ahead of the next grant
    e0 = ev.size(); b0 = byte_log.size(); nb0 = baud_log.size();
    step(); req_data[63:32] = 32'h0000BEEF; req_len[3:2] = 2'd1; req[1] = 1'b1;
    wait_gnt(id); chk("t4_gnt1", id, 1);
    step(); req[1] = 1'b0;
    wait_wrtx(2);
    step(); cfg_div = 9'd3; cfg_wr = 1'b1;
    req_data[95:64] = 32'h5A; req_len[5:4] = 2'd0; req[2] = 1'b1;
    step(); cfg_wr = 1'b0;
    wait_done(id, cyc); chk("t4_done1", id, 1);
    wait_gnt(id); chk("t4_gnt2", id, 2);
    #1;
    chk("t4_ev0", ev[e0], 1);
    chk("t4_ev1", ev[e0+1], 17);
    chk("t4_ev2", ev[e0+2], 32);
    chk("t4_ev3", ev[e0+3], 2);
    chk("t4_baud_cnt", baud_log.size() - nb0, 1);
    chk("t4_baud_val", baud_log[nb0], 32'h3);
    chk("t4_byte0", byte_log[b0], 8'hEF);
    chk("t4_byte1", byte_log[b0+1], 8'hBE);
    step(); req[2] = 1'b0;
    wait_done(id, cyc); chk("t4_done2", id, 2);
    chk("t4_fast_frame", cyc < 28, 1);
    #1;
    chk("t4_byte2", byte_log[b0+2], 8'h5A);

    // Two config strobes while busy collapse into one write of the latest value
    nb0 = baud_log.size();
    step(); req_data[127:96] = 32'h77; req_len[7:6] = 2'd0; req[3] = 1'b1;
    wait_gnt(id); chk("t5_gnt", id, 3);
    step(); req[3] = 1'b0; cfg_div = 9'd5; cfg_wr = 1'b1;
    step(); cfg_wr = 1'b0;
    step(); cfg_div = 9'd9; cfg_wr = 1'b1;
    step(); cfg_wr = 1'b0;
    chk("t5_no_early_baud", baud_log.size() - nb0, 0);
    wait_done(id, cyc); chk("t5_done", id, 3);
    repeat (6) @(negedge clk);
    #1;
    chk("t5_baud_cnt", baud_log.size() - nb0, 1);
    chk("t5_baud_val", baud_log[nb0], 32'h9);
    chk("t5_idle", busy, 0);

    // Reset during the third byte: abandoned, INIT re-runs with the default divider
    e0 = ev.size(); b0 = byte_log.size(); nb0 = baud_log.size();
    step(); req_data[31:0] = 32'hDDCCBBAA; req_len[1:0] = 2'd3; req[0] = 1'b1;
    wait_gnt(id); chk("t6_gnt0", id, 0);
    step(); req[0] = 1'b0;
    wait_wrtx(3);
    #1; rst_n = 1'b0;
    #1;
    chk("t6_rst_wrtx", uart_wrtx, 0);
    chk("t6_rst_busy", busy, 1);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_d", uart_d, 0);
    req_data[63:32] = 32'h12; req_len[3:2] = 2'd0; req = 4'b0011;
    e1 = ev.size();
    step(); step(); rst_n = 1'b1;
    wait_gnt(id); chk("t6_first_after_rst", id, 0);
    step(); req[0] = 1'b0;
    wait_done(id, cyc); chk("t6_done0", id, 0);
    wait_gnt(id); chk("t6_gnt1", id, 1);
    step(); req[1] = 1'b0;
    wait_done(id, cyc); chk("t6_done1", id, 1);
    #1;
    chk("t6_no_done_before_rst", e1 - e0, 1);
    chk("t6_ev_baud", ev[e1], 32);
    chk("t6_baud_cnt", baud_log.size() - nb0, 1);
    chk("t6_baud_val", baud_log[nb0], 32'h7);
    chk("t6_ev_g0", ev[e1+1], 0);
    chk("t6_ev_d0", ev[e1+2], 16);
    chk("t6_ev_g1", ev[e1+3], 1);
    chk("t6_ev_d1", ev[e1+4], 17);
    chk("t6_nbytes", byte_log.size() - b0, 8);
    for (int k = 0; k < 3; k++) chk("t6_pre_byte", byte_log[b0+k], exp6[k]);
    for (int k = 0; k < 5; k++) chk("t6_post_byte", byte_log[b0+3+k], exp6[k]);

    chk("invariants", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UARTB_CORE transmitter among N requesters.
- Each requester hands over one 32-bit word plus a byte count of 1–4 bytes.
- The block splits the word into bytes and feeds them to the core in normal mode (d[31]=0), one wrtx per byte, paced by thre; it then waits for tend before signalling completion.
- It also owns baud/mode configuration: wrbaud after reset, and on request when the transmitter is idle.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of cur_id; must be ≥ clog2(N).
- DEF_DIV, 7, divider written to the core after reset (9 bits).
- GUARD_CYC, 2, cycles waited after each wrtx before thre/tend are sampled again (1..7).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  request level per requester; held until gnt.
- req_data  in  32*N  word of requester i at [32i+31:32i]; held until gnt.
- req_len  in  2*N  byte count minus 1 for requester i at [2i+1:2i]; 0 means 1 byte, 3 means 4 bytes.
- gnt  out  N  one-cycle one-hot pulse; data and length are latched in this cycle.
- done  out  N  one-cycle pulse to the owner after its last byte has fully left (tend).
- cfg_div  in  9  new baud divider.
- cfg_wr  in  1  one-cycle strobe; cfg_div is captured into a pending register.
- uart_d  out  32  to core d.
- uart_wrtx  out  1  to core wrtx.
- uart_wrbaud  out  1  to core wrbaud.
- uart_thre  in  1  from core thre.
- uart_tend  in  1  from core tend.
- busy  out  1  high in any state except IDLE.
- cur_id  out  IDW  index of the current owner; valid while busy and not in INIT or CFG.

Behaviour:
- Reset values:
  - gnt=0, done=0, uart_wrtx=0, uart_wrbaud=0, uart_d=0, busy=1, cur_id=0.
  - State=INIT; round-robin pointer last=N-1, so requester 0 is first.
  - cfg_pend=0, div_reg=DEF_DIV.
- INIT: one cycle with uart_wrbaud=1 and uart_d={1'b0,22'b0,div_reg}, then IDLE.
- IDLE:
  - If cfg_pend=1: go to CFG. Config has priority over grants.
  - Else if req≠0: grant the first set bit searching last+1, last+2, … modulo N.
    - gnt[i]=1 for exactly one cycle; latch word and len; byte index idx=0; last=i; cur_id=i; go to ISSUE.
  - Else stay; busy=0.
- CFG: one cycle with uart_wrbaud=1 and uart_d={1'b0,22'b0,div_reg}; clear cfg_pend; return to IDLE. Both the INIT and CFG writes clear bit 31, so the core is always held in normal mode.
- cfg_wr handling:
  - Sets cfg_pend=1 and div_reg=cfg_div in any state. The latest write wins.
  - cfg_wr in the same cycle that CFG clears the pend re-sets it; the set wins.
- ISSUE:
  - While uart_thre=0: wait with uart_wrtx=0.
  - When uart_thre=1: one cycle with uart_wrtx=1 and uart_d={24'b0, word[8*idx+7:8*idx]}; go to GUARD.
  - Byte order is LSB first: bits [7:0] go first.
- GUARD:
  - Count GUARD_CYC cycles; uart_wrtx=0 and uart_d=0.
  - Then, if idx==len, go to DRAIN; else idx=idx+1 and go to ISSUE.
- DRAIN: wait for uart_tend=1. On that cycle done[cur_id]=1 for one cycle, then IDLE. The next grant is possible in the cycle after done.
- Requests:
  - req from a requester that has a transfer in flight is ignored until done.
  - If req is still high after done, it is treated as a new request and competes under round-robin.
  - With all N requesting continuously, grants rotate 0,1,…,N-1,0.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). A partially sent word is abandoned with no done pulse. INIT re-runs after release.
- uart_wrtx and uart_wrbaud are never high in the same cycle. At most one of each is high per cycle.

Test Plan:
- Reset release → exactly one uart_wrbaud pulse with uart_d=0x00000007; then busy=0, with no wrtx.
- req[0]=1, req_data0=0x11223344, len0=3 → gnt[0] pulses once, then four wrtx pulses with d[7:0]=0x44,0x33,0x22,0x11, each issued only while thre=1; done[0] pulses once after tend; loopback rx sees the same four bytes in order.
- req=4'b1111 held, all len=0, data0..3=0xA0..0xA3 → gnt order 0,1,2,3,0; each done precedes the next gnt; bytes 0xA0,0xA1,0xA2,0xA3 are transmitted.
- cfg_wr with cfg_div=3 during the second byte of a 2-byte transfer → no wrbaud until after done; then one wrbaud with d=0x00000003 before the next gnt; the following frames are at the faster baud.
- Two cfg_wr strobes while busy, with div=5 then div=9 → a single wrbaud with d=0x00000009.
- rst_n low during the third byte of a 4-byte word → uart_wrtx=0 at once, no done; after release INIT writes div=7 and requester 0 is granted first.
